// File: rtl/mem_fill_arbiter.sv
// Arbitrates D-cache misses, write-through stores and I-cache misses onto one memory port,
// streaming 8-word block refills back into the owning cache's data and tag arrays.
module mem_fill_arbiter #(
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_miss,
    input  logic [AWIDTH-1:0] d_miss_addr,
    input  logic              i_miss,
    input  logic [AWIDTH-1:0] i_miss_addr,
    input  logic              st_req,
    input  logic [AWIDTH-1:0] st_addr,
    input  logic [DWIDTH-1:0] st_data,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    output logic              d_data_wen,
    output logic              d_tag_wen,
    output logic              i_data_wen,
    output logic              i_tag_wen,
    output logic [AWIDTH-1:0] fill_word_addr,
    output logic              busy,
    output logic              st_ack
);

    localparam int unsigned IssW = $clog2(WORDS) + 1;
    localparam int unsigned RcvW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AWIDTH-1:0] BlockMask = ~AWIDTH'(2 * WORDS - 1);
    localparam logic [IssW-1:0]   IssLast   = IssW'(WORDS);
    localparam logic [RcvW-1:0]   RcvLast   = RcvW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;
    typedef enum logic {OwnD, OwnI} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [IssW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [RcvW-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic              last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnD;
            base_q      <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        base_d         = base_q;
        issue_cnt_d    = issue_cnt_q;
        rcv_cnt_d      = rcv_cnt_q;
        last_word      = 1'b0;
        mem_en         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        d_data_wen     = 1'b0;
        d_tag_wen      = 1'b0;
        i_data_wen     = 1'b0;
        i_tag_wen      = 1'b0;
        fill_word_addr = '0;
        st_ack         = 1'b0;
        busy           = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (d_miss) begin
                    state_d     = StFill;
                    owner_d     = OwnD;
                    base_d      = d_miss_addr & BlockMask;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                end else if (st_req) begin
                    state_d = StWrite;
                end else if (i_miss) begin
                    state_d     = StFill;
                    owner_d     = OwnI;
                    base_d      = i_miss_addr & BlockMask;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                end
            end
            StFill: begin
                if (issue_cnt_q < IssLast) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + (AWIDTH'(issue_cnt_q) << 1);
                    issue_cnt_d = issue_cnt_q + IssW'(1);
                end
                if (mem_data_valid) begin
                    last_word      = (rcv_cnt_q == RcvLast);
                    fill_word_addr = base_q + (AWIDTH'(rcv_cnt_q) << 1);
                    rcv_cnt_d      = rcv_cnt_q + RcvW'(1);
                    if (owner_q == OwnD) begin
                        d_data_wen = 1'b1;
                        d_tag_wen  = last_word;
                    end else begin
                        i_data_wen = 1'b1;
                        i_tag_wen  = last_word;
                    end
                    if (last_word) begin
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = st_addr;
                mem_data_in = st_data;
                st_ack      = 1'b1;
                state_d     = StIdle;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Force a quiet port while reset is held, whatever the current state is.
        if (rst) begin
            mem_en         = 1'b0;
            mem_wr         = 1'b0;
            mem_addr       = '0;
            mem_data_in    = '0;
            d_data_wen     = 1'b0;
            d_tag_wen      = 1'b0;
            i_data_wen     = 1'b0;
            i_tag_wen      = 1'b0;
            fill_word_addr = '0;
            busy           = 1'b0;
            st_ack         = 1'b0;
        end
    end

endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL have parameters AWIDTH=16 (address bits), DWIDTH=16 (data bits) and WORDS=8 (16-bit words per cache block).
REQ-002 SHALL use one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-003 clk  in  1  system clock, all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 d_miss  in  1  D-cache miss pending (level).
REQ-006 d_miss_addr  in  AWIDTH  D-cache miss byte address.
REQ-007 i_miss  in  1  I-cache miss pending (level).
REQ-008 i_miss_addr  in  AWIDTH  I-cache miss byte address.
REQ-009 st_req  in  1  write-through store request (level, held until st_ack).
REQ-010 st_addr  in  AWIDTH  store byte address; st_data  in  DWIDTH  store data.
REQ-011 mem_data_valid  in  1  main memory read data valid (fixed 4-cycle pipelined latency).
REQ-012 mem_en  out  1  memory enable; mem_wr  out  1  memory write.
REQ-013 mem_addr  out  AWIDTH  memory address; mem_data_in  out  DWIDTH  memory write data.
REQ-014 d_data_wen, d_tag_wen, i_data_wen, i_tag_wen  out  1 each  cache data and tag array write enables.
REQ-015 fill_word_addr  out  AWIDTH  byte address of the word currently written into the cache.
REQ-016 busy  out  1  high in every state except IDLE; st_ack  out  1  one-cycle store completion pulse.

Function
REQ-017 SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-018 IDLE arbitration SHALL use fixed priority: d_miss first, then st_req, then i_miss; the grant is registered, and the next state is FILL for a miss or WRITE for a store.
REQ-019 On a miss grant, the block SHALL latch owner (D/I) and base = miss_addr & ~(2*WORDS-1), i.e. 0xFFF0.
REQ-020 FILL SHALL issue reads with mem_en=1 and mem_wr=0, mem_addr = base + 2*issue_cnt, on the first 8 FILL cycles back-to-back, with issue_cnt running 0..7 and then saturating at 8 with mem_en=0.
REQ-021 FILL SHALL track returns: each mem_data_valid asserts the owner's data_wen for that same cycle, with fill_word_addr = base + 2*rcv_cnt; rcv_cnt then increments.
REQ-022 On the return with rcv_cnt==7, the owner's tag_wen SHALL assert in the same cycle as data_wen, and the next state is DONE.
REQ-023 A nominal fill is 8 issue cycles plus the 4-cycle latency, giving the last word at FILL cycle 11.
REQ-024 DONE SHALL last 1 cycle with no grant and no memory access, then go to IDLE; this lets the cache drop its miss before re-arbitration.
REQ-025 WRITE SHALL last 1 cycle with mem_en=1, mem_wr=1, mem_addr=st_addr, mem_data_in=st_data and st_ack=1, then go to IDLE.
REQ-026 A grant SHALL be non-preemptive: a request deasserting mid-fill does not abort the fill, and new requests wait in their inputs.
REQ-027 mem_data_valid outside FILL SHALL be ignored, meaning no wen and no counter change.
REQ-028 Non-owner cache enables SHALL be 0 at all times, and a data_wen or tag_wen of either cache never asserts outside FILL.
REQ-029 When mem_en=0, mem_wr SHALL be 0 and mem_addr and mem_data_in are don't-care (drive 0).
REQ-030 Address arithmetic SHALL be modulo 2^AWIDTH, so base 0xFFF0 fills through 0xFFFE with no carry out.
REQ-031 A store request arriving during FILL or DONE SHALL be serviced at the next IDLE unless d_miss is also present, in which case d_miss wins.

Reset
REQ-032 Under rst, the next state SHALL be IDLE, with issue_cnt=0, rcv_cnt=0, owner=D and base=0.
REQ-033 While in reset and the cycle after, all outputs SHALL be 0: mem_en, mem_wr, mem_addr, mem_data_in, all wens, fill_word_addr, busy and st_ack.
REQ-034 Reset mid-fill SHALL abandon the fill; in-flight mem_data_valid pulses produce no wen, and no partial tag_wen ever asserts.

Verification
REQ-035 d_miss=1 with d_miss_addr=0x1234 only: reads to 0x1230..0x123E on FILL cycles 0-7, d_data_wen pulses at cycles 4-11 with fill_word_addr 0x1230..0x123E, d_tag_wen with the last, busy falls after DONE.
REQ-036 d_miss at 0x0040 and i_miss at 0x2000 together: the D fill of 0x0040..0x004E completes first, then DONE, then the I fill of 0x2000..0x200E; i_data_wen is silent during the D fill.
REQ-037 st_req with st_addr=0x0100 and st_data=0xBEEF in IDLE: exactly one cycle of mem_en=mem_wr=1 with addr 0x0100 and data 0xBEEF, a 1-cycle st_ack, then IDLE.
REQ-038 rst after the 3rd returned word of a fill at 0x0500: the next cycle shows all outputs 0; the remaining 5 valid pulses produce no wen; a later d_miss refill works normally.
REQ-039 i_miss at 0xFFF8 deasserted at FILL cycle 2: the fill still covers 0xFFF0..0xFFFE with 8 i_data_wen pulses and 1 i_tag_wen.
REQ-040 st_req raised during a D fill: held until DONE, then WRITE in the first IDLE cycle with st_ack; memory never sees a write during FILL.
